// File: rtl/regfile_sb.sv
// regfile_sb
//   Multi-read-port pipeline register file with write-to-read bypass and a
//   per-register pending-write scoreboard. Decode reads operands and issues
//   destination registers; writeback retires them. Register 0 reads as zero.
//   Addresses at or above DEPTH read as zero and ignore writes and issues.
//
// Ports
//   clk       rising-edge clock
//   reset     synchronous, active-high reset
//   rd_addr   NUM_RD packed read addresses, port i at [i*ADDR_W +: ADDR_W]
//   rd_data   NUM_RD packed read data (combinational), port i at [i*DATA_W +: DATA_W]
//   rd_busy   per read port: operand has an unresolved pending write
//   wr_en     writeback strobe
//   wr_addr   writeback register
//   wr_data   writeback data
//   iss_en    issue strobe: mark iss_addr pending
//   iss_addr  destination register of the issued instruction
//   pend_vec  scoreboard contents, bit r = register r pending
//   sb_err    sticky scoreboard protocol violation flag
module regfile_sb #(
  parameter int          DATA_W  = 32,
  parameter int          DEPTH   = 32,
  parameter int          ADDR_W  = 5,
  parameter int          NUM_RD  = 2,
  parameter int          BYPASS  = 1,
  parameter int          SP_IDX  = 29,
  parameter logic [31:0] SP_INIT = 32'h0000_0400
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     iss_en,
  input  logic [ADDR_W-1:0]        iss_addr,
  output logic [DEPTH-1:0]         pend_vec,
  output logic                     sb_err
);

  // Storage spans the full address space so any address indexes it directly;
  // entries 0 and >= DEPTH are never written and stay at their reset zero.
  localparam int NREG = 1 << ADDR_W;
  localparam logic [DATA_W-1:0] SP_VAL = DATA_W'(SP_INIT);

  function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
    return (a != '0) && (int'(a) < DEPTH);
  endfunction

  logic [DATA_W-1:0] regs_reg [NREG];
  logic [DEPTH-1:0]  pend_reg;
  logic [DEPTH-1:0]  pend_next;
  logic [NREG-1:0]   pend_full;
  logic              sb_err_reg;

  logic wr_ok;
  logic iss_ok;
  logic err_iss;
  logic err_wr;

  assign wr_ok     = wr_en && addr_ok(wr_addr);
  assign iss_ok    = iss_en && addr_ok(iss_addr);
  assign pend_full = NREG'(pend_reg);

  // Re-issuing a pending register is only legal when the same-cycle
  // writeback retires the old producer.
  assign err_iss = iss_ok && pend_full[iss_addr] && !(wr_ok && (wr_addr == iss_addr));
  // A writeback must retire something that was issued.
  assign err_wr  = wr_ok && !pend_full[wr_addr];

  // Write clears first, issue sets afterwards, so a same-cycle issue and
  // write to one register leaves it pending for the new producer.
  always_comb begin
    pend_next = pend_reg;
    for (int r = 1; r < DEPTH; r++) begin
      if (wr_ok && (wr_addr == ADDR_W'(r))) pend_next[r] = 1'b0;
      if (iss_ok && (iss_addr == ADDR_W'(r))) pend_next[r] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < NREG; r++) begin
        regs_reg[r] <= ((SP_IDX != 0) && (r == SP_IDX) && (SP_IDX < DEPTH)) ? SP_VAL : '0;
      end
      pend_reg   <= '0;
      sb_err_reg <= 1'b0;
    end else begin
      if (wr_ok) regs_reg[wr_addr] <= wr_data;
      pend_reg <= pend_next;
      if (err_iss || err_wr) sb_err_reg <= 1'b1;
    end
  end

  for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic              ok;
    logic              hit;

    assign addr = rd_addr[gi*ADDR_W +: ADDR_W];
    assign ok   = addr_ok(addr);
    // wr_ok already implies a valid nonzero address, so a hit implies ok.
    assign hit  = (BYPASS != 0) && wr_ok && (wr_addr == addr);

    assign rd_data[gi*DATA_W +: DATA_W] = !ok ? '0 : (hit ? wr_data : regs_reg[addr]);
    // A forwarded operand is resolved even though its pend bit clears only at the edge.
    assign rd_busy[gi] = ok && pend_full[addr] && !hit;
  end

  assign pend_vec = pend_reg;
  assign sb_err   = sb_err_reg;

endmodule

// File: tb/tb_regfile_sb.sv
module tb_regfile_sb;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        iss_en;
  logic [4:0]  iss_addr;
  logic [9:0]  rd_ab;
  logic [19:0] rd_c;

  logic [63:0]  rd_data_a, rd_data_b;
  logic [1:0]   rd_busy_a, rd_busy_b;
  logic [31:0]  pend_a, pend_b;
  logic         err_a, err_b;
  logic [127:0] rd_data_c;
  logic [3:0]   rd_busy_c;
  logic [15:0]  pend_c;
  logic         err_c;

  // Instance 0: default build with bypass.
  regfile_sb #(.BYPASS(1)) u_a (
    .clk(clk), .reset(reset), .rd_addr(rd_ab), .rd_data(rd_data_a), .rd_busy(rd_busy_a),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .iss_en(iss_en), .iss_addr(iss_addr),
    .pend_vec(pend_a), .sb_err(err_a));

  // Instance 1: no forwarding.
  regfile_sb #(.BYPASS(0)) u_b (
    .clk(clk), .reset(reset), .rd_addr(rd_ab), .rd_data(rd_data_b), .rd_busy(rd_busy_b),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .iss_en(iss_en), .iss_addr(iss_addr),
    .pend_vec(pend_b), .sb_err(err_b));

  // Instance 2: four ports, 16 registers, no stack-pointer preload.
  regfile_sb #(.DEPTH(16), .NUM_RD(4), .SP_IDX(0), .BYPASS(1)) u_c (
    .clk(clk), .reset(reset), .rd_addr(rd_c), .rd_data(rd_data_c), .rd_busy(rd_busy_c),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .iss_en(iss_en), .iss_addr(iss_addr),
    .pend_vec(pend_c), .sb_err(err_c));

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  int m_depth [3] = '{32, 32, 16};
  bit m_byp   [3] = '{1'b1, 1'b0, 1'b1};
  int m_sp    [3] = '{29, 29, 0};

  logic [31:0] m_regs [3][32];
  logic [31:0] m_pend [3];
  logic        m_err  [3];
  bit          model_valid = 1'b0;

  function automatic bit valid(input int i, input logic [4:0] a);
    return (a != 5'd0) && (int'(a) < m_depth[i]);
  endfunction

  function automatic bit wv(input int i);
    return wr_en && valid(i, wr_addr);
  endfunction

  function automatic bit iv(input int i);
    return iss_en && valid(i, iss_addr);
  endfunction

  function automatic logic [31:0] pend_after(input int i);
    logic [31:0] p;
    p = m_pend[i];
    if (wv(i)) p[wr_addr] = 1'b0;
    if (iv(i)) p[iss_addr] = 1'b1;
    return p;
  endfunction

  function automatic bit err_now(input int i);
    return (iv(i) && m_pend[i][iss_addr] && !(wv(i) && (wr_addr == iss_addr))) ||
           (wv(i) && !m_pend[i][wr_addr]);
  endfunction

  function automatic logic [31:0] exp_data(input int i, input logic [4:0] a);
    if (!valid(i, a)) return 32'h0;
    if (m_byp[i] && wv(i) && (wr_addr == a)) return wr_data;
    return m_regs[i][a];
  endfunction

  function automatic logic exp_busy(input int i, input logic [4:0] a);
    if (!valid(i, a)) return 1'b0;
    if (m_byp[i] && wv(i) && (wr_addr == a)) return 1'b0;
    return m_pend[i][a];
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      model_valid <= 1'b1;
      for (int i = 0; i < 3; i++) begin
        for (int r = 0; r < 32; r++)
          m_regs[i][r] <= ((m_sp[i] != 0) && (r == m_sp[i])) ? 32'h0000_0400 : 32'h0;
        m_pend[i] <= 32'h0;
        m_err[i]  <= 1'b0;
      end
    end else if (model_valid) begin
      for (int i = 0; i < 3; i++) begin
        if (wv(i)) m_regs[i][wr_addr] <= wr_data;
        m_pend[i] <= pend_after(i);
        if (err_now(i)) m_err[i] <= 1'b1;
      end
    end
  end

  // Every cycle: all outputs of all instances against the model.
  always @(negedge clk) begin
    if (model_valid) begin
      for (int p = 0; p < 2; p++) begin
        chk($sformatf("a_rd_data%0d", p), rd_data_a[p*32 +: 32], exp_data(0, rd_ab[p*5 +: 5]));
        chk($sformatf("a_rd_busy%0d", p), 32'(rd_busy_a[p]), 32'(exp_busy(0, rd_ab[p*5 +: 5])));
        chk($sformatf("b_rd_data%0d", p), rd_data_b[p*32 +: 32], exp_data(1, rd_ab[p*5 +: 5]));
        chk($sformatf("b_rd_busy%0d", p), 32'(rd_busy_b[p]), 32'(exp_busy(1, rd_ab[p*5 +: 5])));
      end
      for (int p = 0; p < 4; p++) begin
        chk($sformatf("c_rd_data%0d", p), rd_data_c[p*32 +: 32], exp_data(2, rd_c[p*5 +: 5]));
        chk($sformatf("c_rd_busy%0d", p), 32'(rd_busy_c[p]), 32'(exp_busy(2, rd_c[p*5 +: 5])));
      end
      chk("a_pend_vec", pend_a, m_pend[0]);
      chk("b_pend_vec", pend_b, m_pend[1]);
      chk("c_pend_vec", 32'(pend_c), 32'(m_pend[2][15:0]));
      chk("a_sb_err", 32'(err_a), 32'(m_err[0]));
      chk("b_sb_err", 32'(err_b), 32'(m_err[1]));
      chk("c_sb_err", 32'(err_c), 32'(m_err[2]));
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle();
    wr_en = 1'b0; wr_addr = 5'd0; wr_data = 32'h0;
    iss_en = 1'b0; iss_addr = 5'd0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; idle(); rd_ab = 10'd0; rd_c = 20'd0;
    step(); step();
    reset = 1'b0;

    // Reset contents: stack pointer preload, everything else zero.
    rd_ab = {5'd5, 5'd29};
    settle();
    chk("lit_rst_r29", rd_data_a[31:0], 32'h0000_0400);
    chk("lit_rst_r5", rd_data_a[63:32], 32'h0);
    chk("lit_rst_pend", pend_a, 32'h0);
    chk("lit_rst_err", 32'(err_a), 32'h0);
    chk("lit_model_sp", m_regs[0][29], 32'h0000_0400);

    // Issue r7, then write it while port 0 reads it.
    step();
    rd_ab = {5'd0, 5'd7}; iss_en = 1'b1; iss_addr = 5'd7;
    step();
    iss_en = 1'b0; wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'hDEAD_BEEF;
    settle();
    chk("lit_byp_data", rd_data_a[31:0], 32'hDEAD_BEEF);
    chk("lit_byp_busy", 32'(rd_busy_a[0]), 32'h0);
    chk("lit_nobyp_data", rd_data_b[31:0], 32'h0);
    chk("lit_nobyp_busy", 32'(rd_busy_b[0]), 32'h1);
    step();
    idle();
    settle();
    chk("lit_pend7_clear", 32'(pend_a[7]), 32'h0);
    chk("lit_nobyp_data_next", rd_data_b[31:0], 32'hDEAD_BEEF);
    chk("lit_nobyp_busy_next", 32'(rd_busy_b[0]), 32'h0);

    // r0 is hardwired: write and issue ignored, no error.
    step();
    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFF_FFFF;
    iss_en = 1'b1; iss_addr = 5'd0; rd_ab = 10'd0; rd_c = 20'd0;
    settle();
    chk("lit_r0_port0", rd_data_a[31:0], 32'h0);
    chk("lit_r0_port1", rd_data_a[63:32], 32'h0);
    chk("lit_r0_busy", 32'(rd_busy_a), 32'h0);
    chk("lit_r0_c_port3", rd_data_c[127:96], 32'h0);
    step();
    idle();
    settle();
    chk("lit_r0_err", 32'(err_a), 32'h0);

    // Double issue without writeback is a protocol error.
    step();
    iss_en = 1'b1; iss_addr = 5'd3;
    step();
    step();
    idle();
    settle();
    chk("lit_double_iss_err", 32'(err_a), 32'h1);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;

    // Same-cycle issue and write to a pending register.
    iss_en = 1'b1; iss_addr = 5'd3;
    step();
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h0000_1234;
    step();
    idle(); rd_ab = {5'd0, 5'd3};
    settle();
    chk("lit_iss_wr_pend3", 32'(pend_a[3]), 32'h1);
    chk("lit_iss_wr_err", 32'(err_a), 32'h0);
    chk("lit_iss_wr_data", rd_data_a[31:0], 32'h0000_1234);
    chk("lit_iss_wr_busy", 32'(rd_busy_a[0]), 32'h1);

    // Reset overrides a coincident write and issue.
    step();
    reset = 1'b1; wr_en = 1'b1; wr_addr = 5'd4; wr_data = 32'h55;
    iss_en = 1'b1; iss_addr = 5'd4;
    step();
    reset = 1'b0; idle(); rd_ab = {5'd0, 5'd4};
    settle();
    chk("lit_rst_wr_data", rd_data_a[31:0], 32'h0);
    chk("lit_rst_wr_pend", pend_a, 32'h0);
    chk("lit_rst_wr_err", 32'(err_a), 32'h0);

    // Four-port, 16-entry instance.
    step();
    wr_en = 1'b1; wr_addr = 5'd1; wr_data = 32'h0000_00A1;
    step();
    wr_addr = 5'd15; wr_data = 32'h0000_0F15;
    step();
    idle(); rd_c = {5'd0, 5'd1, 5'd15, 5'd1};
    settle();
    chk("lit_c_port0", rd_data_c[31:0], 32'h0000_00A1);
    chk("lit_c_port1", rd_data_c[63:32], 32'h0000_0F15);
    chk("lit_c_port2", rd_data_c[95:64], 32'h0000_00A1);
    chk("lit_c_port3", rd_data_c[127:96], 32'h0);
    step();
    rd_c[4:0] = 5'd20;
    settle();
    chk("lit_c_addr20", rd_data_c[31:0], 32'h0);
    chk("lit_c_addr20_busy", 32'(rd_busy_c[0]), 32'h0);

    // Randomised traffic; occasional resets clear the sticky error.
    repeat (3000) begin
      step();
      reset    = ($urandom_range(0, 39) == 0);
      wr_en    = 1'($urandom_range(0, 1));
      wr_addr  = 5'($urandom_range(0, 31));
      wr_data  = $urandom();
      iss_en   = 1'($urandom_range(0, 1));
      iss_addr = 5'($urandom_range(0, 31));
      rd_ab    = 10'($urandom());
      rd_c     = 20'($urandom());
      if ($urandom_range(0, 2) == 0) rd_ab[4:0] = wr_addr;
      if ($urandom_range(0, 2) == 0) rd_c[9:5] = wr_addr;
      if ($urandom_range(0, 3) == 0) iss_addr = wr_addr;
    end
    step();
    idle();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
